// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - run/stop controller for a glitch-free 50% duty clock divider
// Divisor changes land only on half-period boundaries; stopping always parks CLK_out low.
module clk_div_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 20000000
) (
  input  logic             CLK_in,
  input  logic             RST_n,
  input  logic             run_en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             CLK_out,
  output logic             tick,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_STOP_WAIT = 2'd2,
    S_UNUSED    = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] div_active_q, div_active_d;
  logic [WIDTH-1:0] div_pending_q, div_pending_d;
  logic             pend_flag_q, pend_flag_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;

  logic term;
  logic cfg_xfer;
  logic cfg_zero;

  assign term      = (counter_q == (div_active_q - WIDTH'(1)));
  assign cfg_ready = !pend_flag_q;
  assign cfg_xfer  = cfg_valid && cfg_ready;
  assign cfg_zero  = (cfg_div == '0);

  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    div_active_d  = div_active_q;
    div_pending_d = div_pending_q;
    pend_flag_d   = pend_flag_q;
    clk_out_d     = clk_out_q;
    tick_d        = 1'b0;
    cfg_err_d     = cfg_xfer && cfg_zero;

    case (state_q)
      S_IDLE: begin
        counter_d = '0;
        clk_out_d = 1'b0;
        if (cfg_xfer && !cfg_zero) div_active_d = cfg_div;
        if (run_en) state_d = S_RUN;
      end

      S_RUN, S_STOP_WAIT: begin
        // Pending apply and a new transfer can never coincide: a transfer needs pend_flag=0.
        if (cfg_xfer && !cfg_zero) begin
          div_pending_d = cfg_div;
          pend_flag_d   = 1'b1;
        end
        if (term && pend_flag_q) begin
          div_active_d = div_pending_q;
          pend_flag_d  = 1'b0;
        end

        if (state_q == S_RUN && !run_en && !clk_out_q) begin
          state_d   = S_IDLE;
          counter_d = '0;
        end else begin
          if (term) begin
            counter_d = '0;
            clk_out_d = !clk_out_q;
            tick_d    = 1'b1;
          end else begin
            counter_d = counter_q + WIDTH'(1);
          end
          // A stop request while high finishes the high phase, then parks in IDLE.
          if (run_en)    state_d = S_RUN;
          else if (term) state_d = S_IDLE;
          else           state_d = S_STOP_WAIT;
        end
      end

      default: begin
        state_d   = S_IDLE;
        counter_d = '0;
        clk_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_in or negedge RST_n) begin
    if (!RST_n) begin
      state_q       <= S_IDLE;
      counter_q     <= '0;
      div_active_q  <= DEF_DIV;
      div_pending_q <= '0;
      pend_flag_q   <= 1'b0;
      clk_out_q     <= 1'b0;
      tick_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      div_active_q  <= div_active_d;
      div_pending_q <= div_pending_d;
      pend_flag_q   <= pend_flag_d;
      clk_out_q     <= clk_out_d;
      tick_q        <= tick_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign CLK_out = clk_out_q;
  assign tick    = tick_q;
  assign cfg_err = cfg_err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - vector table plus scoreboard checks for clk_div_ctrl
module tb_clk_div_ctrl;

  localparam int WIDTH = 8;

  logic             CLK_in;
  logic             RST_n;
  logic             run_en;
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             CLK_out;
  logic             tick;
  logic [1:0]       state;

  clk_div_ctrl #(.WIDTH(WIDTH), .DEFAULT_DIV(3)) dut (
    .CLK_in   (CLK_in),
    .RST_n    (RST_n),
    .run_en   (run_en),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .CLK_out  (CLK_out),
    .tick     (tick),
    .state    (state)
  );

  initial CLK_in = 1'b0;
  always #5 CLK_in = ~CLK_in;

  // exp packs {CLK_out, tick, state[1:0], cfg_ready, cfg_err} after the edge
  typedef struct {
    logic             run;
    logic             vld;
    logic [WIDTH-1:0] div;
    logic [5:0]       exp;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] sb_q[$];
  int         checks;
  int         errors;

  function automatic vec_t mk(input int r, input int v, input int d, input int c,
                              input int t, input int s, input int rd, input int e);
    vec_t x;
    x.run = r[0];
    x.vld = v[0];
    x.div = d[WIDTH-1:0];
    x.exp = {c[0], t[0], s[1:0], rd[0], e[0]};
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] exp_v;
    logic [5:0] act_v;
    int         n;
    int         m;
    checks    = 0;
    errors    = 0;
    RST_n     = 1'b0;
    run_en    = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;

    // start with div 3, mid-period reconfig to 5, zero divisor while running
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,0,0, 1,1,1,1,0));
    vecs.push_back(mk(1,0,0, 1,0,1,1,0));
    vecs.push_back(mk(1,0,0, 1,0,1,1,0));
    vecs.push_back(mk(1,0,0, 0,1,1,1,0));
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,1,5, 0,0,1,0,0));
    vecs.push_back(mk(1,0,0, 1,1,1,1,0));
    vecs.push_back(mk(1,0,0, 1,0,1,1,0));
    vecs.push_back(mk(1,0,0, 1,0,1,1,0));
    vecs.push_back(mk(1,0,0, 1,0,1,1,0));
    vecs.push_back(mk(1,0,0, 1,0,1,1,0));
    vecs.push_back(mk(1,0,0, 0,1,1,1,0));
    vecs.push_back(mk(1,1,0, 0,0,1,1,1));
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,0,0, 1,1,1,1,0));
    // stop while high, then zero divisor and div 4 in IDLE
    vecs.push_back(mk(0,0,0, 1,0,2,1,0));
    vecs.push_back(mk(0,0,0, 1,0,2,1,0));
    vecs.push_back(mk(0,0,0, 1,0,2,1,0));
    vecs.push_back(mk(0,0,0, 1,0,2,1,0));
    vecs.push_back(mk(0,0,0, 0,1,0,1,0));
    vecs.push_back(mk(0,0,0, 0,0,0,1,0));
    vecs.push_back(mk(0,1,4, 0,0,0,1,0));
    vecs.push_back(mk(0,1,0, 0,0,0,1,1));
    vecs.push_back(mk(0,0,0, 0,0,0,1,0));
    // div 4: drop run_en one cycle after the rising toggle
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,0,0, 1,1,1,1,0));
    vecs.push_back(mk(0,0,0, 1,0,2,1,0));
    vecs.push_back(mk(0,0,0, 1,0,2,1,0));
    vecs.push_back(mk(0,0,0, 1,0,2,1,0));
    vecs.push_back(mk(0,0,0, 0,1,0,1,0));
    vecs.push_back(mk(0,0,0, 0,0,0,1,0));
    // stop while low: immediate IDLE, no toggle
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,0,0, 1,1,1,1,0));
    vecs.push_back(mk(1,0,0, 1,0,1,1,0));
    vecs.push_back(mk(1,0,0, 1,0,1,1,0));
    vecs.push_back(mk(1,0,0, 1,0,1,1,0));
    vecs.push_back(mk(1,0,0, 0,1,1,1,0));
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(0,0,0, 0,0,0,1,0));
    // re-raise run_en during STOP_WAIT: phase undisturbed
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,0,0, 1,1,1,1,0));
    vecs.push_back(mk(0,0,0, 1,0,2,1,0));
    vecs.push_back(mk(1,0,0, 1,0,1,1,0));
    vecs.push_back(mk(1,0,0, 1,0,1,1,0));
    vecs.push_back(mk(1,0,0, 0,1,1,1,0));
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    // div 1 (CLK_in/2, tick stuck high), then switch to div 2
    vecs.push_back(mk(0,0,0, 0,0,0,1,0));
    vecs.push_back(mk(0,1,1, 0,0,0,1,0));
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,0,0, 1,1,1,1,0));
    vecs.push_back(mk(1,0,0, 0,1,1,1,0));
    vecs.push_back(mk(1,1,2, 1,1,1,0,0));
    vecs.push_back(mk(1,0,0, 0,1,1,1,0));
    vecs.push_back(mk(1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(1,0,0, 1,1,1,1,0));
    // leave a divisor pending while high, for the reset check below
    vecs.push_back(mk(1,1,7, 1,0,1,0,0));

    repeat (3) @(posedge CLK_in);
    #1;
    chk("reset_clk_out", int'(CLK_out), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_state", int'(state), 0);
    chk("reset_cfg_ready", int'(cfg_ready), 1);
    chk("reset_cfg_err", int'(cfg_err), 0);
    @(negedge CLK_in);
    RST_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK_in);
      run_en    = vecs[i].run;
      cfg_valid = vecs[i].vld;
      cfg_div   = vecs[i].div;
      sb_q.push_back(vecs[i].exp);
      @(posedge CLK_in);
      #1;
      exp_v = sb_q.pop_front();
      act_v = {CLK_out, tick, state, cfg_ready, cfg_err};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL vec%0d clk/tick/state/ready/err: got %b expected %b", i, act_v, exp_v);
      end
    end

    // asynchronous reset mid-cycle with a pending divisor
    #2;
    cfg_valid = 1'b0;
    RST_n     = 1'b0;
    #1;
    chk("async_rst_clk_out", int'(CLK_out), 0);
    chk("async_rst_tick", int'(tick), 0);
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_cfg_ready", int'(cfg_ready), 1);

    // default divisor restored and pending value discarded
    @(negedge CLK_in);
    RST_n  = 1'b1;
    run_en = 1'b1;
    n = 0;
    do begin
      @(posedge CLK_in);
      #1;
      n++;
    end while (!CLK_out && n < 20);
    chk("post_rst_first_rise_edges", n, 4);
    chk("post_rst_rise_tick", int'(tick), 1);
    m = 0;
    do begin
      @(posedge CLK_in);
      #1;
      m++;
    end while (CLK_out && m < 20);
    chk("post_rst_high_len", m, 3);
    chk("post_rst_cfg_ready", int'(cfg_ready), 1);
    run_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run-time controller for the board clock divider. It produces a 50%-duty divided clock (CLK_out) and a matching one-cycle tick from CLK_in. The block owns the run/stop sequencing and accepts new divisor values through a valid/ready handshake. New divisors are applied only at half-period boundaries, and stopping always leaves CLK_out low, so the divided clock never glitches. The block sits between the button/switch front-end and the counter/display logic that consumes CLK_out or tick.

Parameters:
WIDTH, 32, width of divisor and internal counter
DEFAULT_DIV, 20000000, half-period length in CLK_in cycles after reset (must be >= 1)

Ports:
CLK_in  input  1  system clock
RST_n  input  1  asynchronous active-low reset
run_en  input  1  level; 1 = divider running, 0 = request stop
cfg_valid  input  1  new divisor offered
cfg_div  input  WIDTH  new half-period length in CLK_in cycles
cfg_ready  output  1  controller can accept a divisor
cfg_err  output  1  one-cycle pulse: a zero divisor was rejected
CLK_out  output  1  divided clock, period 2*div_active
tick  output  1  one-cycle pulse, high in the cycle after each CLK_out toggle
state  output  2  0=IDLE, 1=RUN, 2=STOP_WAIT

Behaviour:
- Interface: one clock, CLK_in. Reset RST_n is asynchronous and active-low. All outputs are registered except cfg_ready.
- Reset values: state=IDLE, counter=0, div_active=DEFAULT_DIV, pend_flag=0, CLK_out=0, tick=0, cfg_err=0.
- Terminal condition (term): counter == div_active-1. Arithmetic is unsigned, WIDTH bits. counter never exceeds div_active-1 because div_active changes only at term or in IDLE.
- cfg_ready is defined as !pend_flag. A transfer occurs on a clock edge where cfg_valid && cfg_ready.
- Zero divisor: cfg_err=1 for the next cycle only. No register changes and cfg_ready stays 1.
- Non-zero divisor in IDLE: div_active <= cfg_div directly.
- Non-zero divisor in RUN or STOP_WAIT: div_pending <= cfg_div and pend_flag <= 1. cfg_ready stays low until the pending value is applied.
- Pending apply: at any term in RUN or STOP_WAIT with pend_flag=1, div_active <= div_pending and pend_flag <= 0. The new value governs the next half-period.
- A transfer on the same edge as term with pend_flag=0 goes to pending, not active. It is applied at the following term.
- IDLE: counter held at 0 and CLK_out=0. If run_en=1, go to RUN. If a config transfer happens on the same edge, RUN uses the new div_active.
- Start latency: the first CLK_out rise (and tick) occurs div_active edges after the edge that samples run_en=1 in IDLE.
- RUN: counter increments each cycle. At term: counter<=0, CLK_out<=!CLK_out, tick<=1. Otherwise tick<=0.
- Stop from RUN, CLK_out=0: with run_en=0 and CLK_out=0, go to IDLE and set counter<=0. The low phase is truncated with no toggle.
- Stop from RUN, CLK_out=1: with run_en=0 and CLK_out=1, go to STOP_WAIT. Counting continues.
- STOP_WAIT: the high half-period completes. At term, CLK_out<=0, tick<=1, counter<=0, go to IDLE, and any pending divisor is applied.
- STOP_WAIT with run_en=1 again: return to RUN with the counter and CLK_out undisturbed.
- div_active=1: term every cycle. CLK_out toggles every cycle (CLK_in/2) and tick stays high continuously while running.
- Reset mid-operation: immediate return to reset values. Any pending divisor is discarded.
- state encoding 3 is unused. If reached, the FSM goes to IDLE on the next edge with CLK_out<=0.

Test Plan:
1. DEFAULT_DIV=3, release reset, run_en=1 -> CLK_out rises 3 cycles after the sampling edge, then has period 6 at 50% duty; tick pulses every 3 cycles aligned with each toggle; state=1.
2. Running with div 3, transfer cfg_div=5 at counter=1 -> cfg_ready=0 from the accepting edge until term; the current half-period ends after 3 cycles; following half-periods are 5 cycles; cfg_ready returns to 1 after term.
3. cfg_valid=1 with cfg_div=0, in IDLE and in RUN -> cfg_err high exactly 1 cycle, div_active unchanged, cfg_ready stays 1, CLK_out timing unaffected.
4. div 4, drop run_en 1 cycle after a rising toggle -> state=2; CLK_out stays high for the remaining 3 cycles, falls with a tick, then state=0. Repeat with CLK_out=0 -> state=0 on the next edge with no toggle. Re-raise run_en during STOP_WAIT -> back to RUN with no phase disturbance.
5. cfg_div=1 in IDLE, then run_en=1 -> CLK_out toggles every cycle and tick is constantly 1. Then cfg_div=2 -> applied at the next edge (term), after which CLK_out period is 4.
6. Assert RST_n=0 asynchronously mid-RUN with pend_flag=1 -> CLK_out=0, tick=0, state=0, cfg_ready=1, div_active=DEFAULT_DIV, without waiting for a CLK_in edge.
